// File: rtl/maku_bus_pkg.sv
// Shared types and helpers for the GP-side peripheral bridge.
package maku_bus_pkg;

    // Bridge transaction phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bridge_state_t;

    // Read data returned on any failed access
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    // Slot index width: enough for the largest supported slot count (16)
    localparam int SLOT_IDX_W = 4;

    // Window decode: returns {hit, slot index}. The subtraction wraps below
    // the base, so the explicit lower-bound compare is what rejects those.
    function automatic logic [SLOT_IDX_W:0] slot_decode(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int          slot_aw,
        input int          n
    );
        logic [31:0] off;
        logic [31:0] sh;
        logic        hit;
        off = addr - base;
        sh  = off >> slot_aw;
        hit = (addr >= base) && (sh < 32'(n));
        slot_decode = {hit, hit ? SLOT_IDX_W'(sh) : {SLOT_IDX_W{1'b0}}};
    endfunction

endpackage

// File: rtl/maku_periph_addr_decoder.sv
// Combinational peripheral window decoder: byte address -> hit, slot index, one-hot select.
module maku_periph_addr_decoder
    import maku_bus_pkg::*;
#(
    parameter int          NUM_SLOTS = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SLOT_AW   = 8
) (
    input  logic [31:0]           addr_i,
    output logic                  hit_o,
    output logic [SLOT_IDX_W-1:0] idx_o,
    output logic [NUM_SLOTS-1:0]  onehot_o
);

    logic [SLOT_IDX_W:0] dec_s;

    // Decode the address into a hit flag, slot index and one-hot select
    always_comb begin
        dec_s    = slot_decode(addr_i, BASE_ADDR, SLOT_AW, NUM_SLOTS);
        hit_o    = dec_s[SLOT_IDX_W];
        idx_o    = dec_s[SLOT_IDX_W-1:0];
        onehot_o = {NUM_SLOTS{1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_o && (idx_o == SLOT_IDX_W'(i))) begin
                onehot_o[i] = 1'b1;
            end else begin
                onehot_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/maku_periph_bridge.sv
// GP data-port to peripheral-slot bridge: one outstanding access, per-slot
// wait states, bus timeout and error reporting. All outputs are registered.
module maku_periph_bridge
    import maku_bus_pkg::*;
#(
    parameter int          NUM_SLOTS = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SLOT_AW   = 8,
    parameter int          REG_AW    = 6,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    m_req,
    input  logic                    m_we,
    input  logic [3:0]              m_be,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    output logic [31:0]             m_rdata,
    output logic                    m_ready,
    output logic                    m_err,
    output logic [NUM_SLOTS-1:0]    s_en,
    output logic                    s_we,
    output logic [3:0]              s_be,
    output logic [REG_AW-1:0]       s_addr,
    output logic [31:0]             s_wdata,
    input  logic [NUM_SLOTS*32-1:0] s_rdata,
    input  logic [NUM_SLOTS-1:0]    s_ready,
    output logic                    err_irq,
    output logic [31:0]             err_addr,
    output logic [7:0]              err_count
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    bridge_state_t         state_q, state_d;
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [SLOT_IDX_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]       cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0]  s_en_q, s_en_d;
    logic                  m_ready_q, m_ready_d;
    logic                  m_err_q, m_err_d;
    logic [31:0]           m_rdata_q, m_rdata_d;
    logic                  err_irq_q, err_irq_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  dec_hit_s;
    logic [SLOT_IDX_W-1:0] dec_idx_s;
    logic [NUM_SLOTS-1:0]  dec_onehot_s;
    logic                  sel_ready_s;
    logic [31:0]           sel_rdata_s;

    maku_periph_addr_decoder #(
        .NUM_SLOTS (NUM_SLOTS),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_AW   (SLOT_AW)
    ) u_dec (
        .addr_i   (m_addr),
        .hit_o    (dec_hit_s),
        .idx_o    (dec_idx_s),
        .onehot_o (dec_onehot_s)
    );

    // Pick the ready flag and read data of the slot currently being accessed
    always_comb begin
        sel_ready_s = |(s_ready & s_en_q);
        sel_rdata_s = 32'h0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == SLOT_IDX_W'(i)) begin
                sel_rdata_s = s_rdata[32*i +: 32];
            end else begin
                sel_rdata_s = sel_rdata_s;
            end
        end
    end

    // Next-state and registered-output logic for the bridge FSM
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        s_en_d      = s_en_q;
        m_ready_d   = 1'b0;
        m_err_d     = 1'b0;
        m_rdata_d   = m_rdata_q;
        err_irq_d   = 1'b0;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (m_req) begin
                    we_d    = m_we;
                    be_d    = m_be;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    idx_d   = dec_idx_s;
                    cnt_d   = {TO_W{1'b0}};
                    if (dec_hit_s) begin
                        state_d = ACCESS;
                        s_en_d  = dec_onehot_s;
                    end else begin
                        // Unmapped: answer straight away with an error
                        state_d   = RESP;
                        m_ready_d = 1'b1;
                        m_err_d   = 1'b1;
                        m_rdata_d = ERR_DATA;
                        err_irq_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (sel_ready_s) begin
                    state_d   = RESP;
                    s_en_d    = {NUM_SLOTS{1'b0}};
                    m_ready_d = 1'b1;
                    m_rdata_d = we_q ? 32'h0 : sel_rdata_s;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    s_en_d    = {NUM_SLOTS{1'b0}};
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b1;
                    m_rdata_d = ERR_DATA;
                    err_irq_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (m_err_q) begin
                    err_addr_d  = addr_q;
                    err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                end else begin
                    err_addr_d  = err_addr_q;
                    err_count_d = err_count_q;
                end
            end
            default: begin
                state_d = IDLE;
                s_en_d  = {NUM_SLOTS{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            idx_q       <= {SLOT_IDX_W{1'b0}};
            cnt_q       <= {TO_W{1'b0}};
            s_en_q      <= {NUM_SLOTS{1'b0}};
            m_ready_q   <= 1'b0;
            m_err_q     <= 1'b0;
            m_rdata_q   <= 32'h0;
            err_irq_q   <= 1'b0;
            err_addr_q  <= 32'h0;
            err_count_q <= 8'h0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            s_en_q      <= s_en_d;
            m_ready_q   <= m_ready_d;
            m_err_q     <= m_err_d;
            m_rdata_q   <= m_rdata_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_ready   = m_ready_q;
    assign m_err     = m_err_q;
    assign m_rdata   = m_rdata_q;
    assign s_en      = s_en_q;
    assign s_we      = we_q;
    assign s_be      = be_q;
    assign s_addr    = addr_q[REG_AW+1:2];
    assign s_wdata   = wdata_q;
    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_maku_periph_bridge.sv
// Scoreboard bench for maku_periph_bridge with a transaction-level reference model.
module tb_maku_periph_bridge;

    localparam int          NS   = 8;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m_req = 1'b0;
    logic              m_we = 1'b0;
    logic [3:0]        m_be = 4'h0;
    logic [31:0]       m_addr = 32'h0;
    logic [31:0]       m_wdata = 32'h0;
    logic [31:0]       m_rdata;
    logic              m_ready;
    logic              m_err;
    logic [NS-1:0]     s_en;
    logic              s_we;
    logic [3:0]        s_be;
    logic [5:0]        s_addr;
    logic [31:0]       s_wdata;
    logic [NS*32-1:0]  s_rdata = '0;
    logic [NS-1:0]     s_ready = '0;
    logic              err_irq;
    logic [31:0]       err_addr;
    logic [7:0]        err_count;

    maku_periph_bridge dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
        .m_err(m_err), .s_en(s_en), .s_we(s_we), .s_be(s_be), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_ready(s_ready), .err_irq(err_irq),
        .err_addr(err_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          issue;
        int          cnt;
        logic [31:0] eaddr;
    } exp_t;

    exp_t        expq[$];
    exp_t        last_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          chk_err_next = 1'b0;

    // reference-model state
    int          mdl_cnt = 0;
    logic [31:0] mdl_eaddr = 32'h0;
    logic [31:0] slot_data [NS];
    logic [NS-1:0] exp_sel = '0;
    logic [31:0] exp_addr = 32'h0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_be = 4'h0;
    logic [31:0] exp_wdata = 32'h0;
    int          wait_n = 0;
    int          en_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // slot model: selected slot answers after wait_n ACCESS cycles; others give noise
    always @(negedge clk) begin
        if (rst) begin
            en_cnt  = 0;
            s_ready = '0;
        end else if (s_en != '0) begin
            chk("s_en", 32'(s_en), 32'(exp_sel));
            chk("s_addr", 32'(s_addr), 32'(exp_addr[7:2]));
            chk("s_we", 32'(s_we), 32'(exp_we));
            chk("s_be", 32'(s_be), 32'(exp_be));
            chk("s_wdata", s_wdata, exp_wdata);
            s_ready = (NS'($urandom) & ~s_en) | ((en_cnt >= wait_n) ? s_en : '0);
            en_cnt++;
        end else begin
            en_cnt  = 0;
            s_ready = NS'($urandom);
        end
    end

    // monitor: pops expected responses whenever the DUT presents m_ready
    always @(negedge clk) begin
        if (chk_err_next && !rst) begin
            chk("err_count", 32'(err_count), 32'(last_e.cnt));
            chk("err_addr", err_addr, last_e.eaddr);
        end
        chk_err_next = 1'b0;
        if (!rst && m_ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_m_ready at cycle %0d", cyc);
            end else begin
                last_e = expq.pop_front();
                chk("m_rdata", m_rdata, last_e.rdata);
                chk("m_err", 32'(m_err), 32'(last_e.err));
                chk("err_irq", 32'(err_irq), 32'(last_e.err));
                chk("latency", 32'(cyc - last_e.issue), 32'(last_e.lat));
                chk_err_next = 1'b1;
                done_cnt++;
            end
        end else if (!rst && err_irq) begin
            checks++;
            failures++;
            $display("FAIL err_irq_without_m_ready actual=1 expected=0 cycle %0d", cyc);
        end
    end

    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input int waitn, input logic [31:0] tgt);
        exp_t   e;
        longint off;
        bit     mapped;
        int     slot;
        int     target;
        @(negedge clk);
        for (int i = 0; i < NS; i++) slot_data[i] = $urandom;
        off    = longint'(addr) - longint'(BASE);
        mapped = (off >= 0) && (off < longint'(NS) * 256);
        slot   = mapped ? int'(off / 256) : 0;
        if (mapped) slot_data[slot] = tgt;
        for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = slot_data[i];
        if (!mapped) begin
            e.err = 1'b1; e.lat = 1; e.rdata = 32'hDEAD_BEEF;
        end else if (waitn < TO) begin
            e.err = 1'b0; e.lat = waitn + 2; e.rdata = we ? 32'h0 : tgt;
        end else begin
            e.err = 1'b1; e.lat = TO + 1; e.rdata = 32'hDEAD_BEEF;
        end
        if (e.err) begin
            mdl_cnt   = (mdl_cnt < 255) ? mdl_cnt + 1 : 255;
            mdl_eaddr = addr;
        end
        e.cnt   = mdl_cnt;
        e.eaddr = mdl_eaddr;
        e.issue = cyc;
        exp_sel   = mapped ? (NS'(1) << slot) : '0;
        exp_addr  = addr; exp_we = we; exp_be = be; exp_wdata = wdata;
        wait_n    = waitn;
        expq.push_back(e);
        target = done_cnt + 1;
        m_req = 1'b1; m_we = we; m_be = be; m_addr = addr; m_wdata = wdata;
        @(negedge clk);
        #1;
        // noise after the request is taken must be ignored
        m_req = 1'b0; m_we = ~we; m_be = 4'($urandom); m_addr = $urandom; m_wdata = $urandom;
        for (int k = 0; k < 60 && done_cnt < target; k++) begin
            @(negedge clk);
            #1;
        end
        if (done_cnt < target) begin
            checks++;
            failures++;
            $display("FAIL response_timeout addr=%h no m_ready within 60 cycles", addr);
            expq.delete();
        end
        exp_sel = '0;
    endtask

    initial begin
        int r;
        int w;
        logic [31:0] a;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_m_err", 32'(m_err), 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_s_en", 32'(s_en), 32'h0);
        chk("rst_s_we_be", {s_we, s_be}, 32'h0);
        chk("rst_s_addr", 32'(s_addr), 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        chk("rst_err_irq", 32'(err_irq), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        #1 rst = 1'b0;

        // directed cases
        do_txn(32'h4000_0208, 1'b0, 4'hF, 32'h0, 0, 32'h1234_5678);
        do_txn(32'h4000_0510, 1'b1, 4'hC, 32'hA5A5_0000, 3, 32'h0);
        do_txn(32'h5000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0);
        do_txn(32'h4000_0004, 1'b0, 4'hF, 32'h0, 1000, 32'h0);
        do_txn(32'h4000_07FF, 1'b0, 4'h3, 32'h0, TO - 1, 32'hCAFE_F00D);
        do_txn(32'h4000_0800, 1'b0, 4'hF, 32'h0, 0, 32'h0);
        do_txn(32'h3FFF_FFFC, 1'b1, 4'h0, 32'h1, 0, 32'h0);
        do_txn(32'h4000_0601, 1'b1, 4'h0, 32'h7777_0001, 0, 32'h0);

        // randomized traffic
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = BASE + 32'($urandom_range(0, NS - 1)) * 32'd256 + 32'($urandom_range(0, 255));
            else if (r < 80) a = BASE - 32'($urandom_range(1, 8));
            else if (r < 90) a = BASE + 32'(NS * 256) + 32'($urandom_range(0, 8));
            else             a = $urandom;
            r = $urandom_range(0, 99);
            if (r < 60)      w = $urandom_range(0, 3);
            else if (r < 80) w = TO - 1;
            else if (r < 90) w = TO;
            else             w = 0;
            do_txn(a, 1'($urandom), 4'($urandom), $urandom, w, $urandom);
        end

        // error counter saturation
        for (int n = 0; n < 300; n++) begin
            do_txn(32'h8000_0000 + 32'(n * 4), 1'b0, 4'hF, 32'h0, 0, 32'h0);
        end
        chk("err_count_saturated", 32'(err_count), 32'd255);

        // reset in the middle of a waiting access
        @(negedge clk);
        exp_sel = NS'(8); exp_addr = 32'h4000_0310; exp_we = 1'b0; exp_be = 4'hF;
        exp_wdata = 32'h0; wait_n = 1000;
        m_req = 1'b1; m_we = 1'b0; m_be = 4'hF; m_addr = 32'h4000_0310; m_wdata = 32'h0;
        @(negedge clk);
        #1 m_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_access_s_en", 32'(s_en), 32'h8);
        #1;
        rst = 1'b1;
        expq.delete();
        exp_sel = '0;
        mdl_cnt = 0;
        mdl_eaddr = 32'h0;
        @(negedge clk);
        chk("abort_s_en", 32'(s_en), 32'h0);
        chk("abort_m_ready", 32'(m_ready), 32'h0);
        chk("abort_err_count", 32'(err_count), 32'h0);
        chk("abort_err_addr", err_addr, 32'h0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        do_txn(32'h4000_0108, 1'b0, 4'hF, 32'h0, 1, 32'h0BAD_F00D);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
